// File: rtl/mod_seq_ctrl_if.sv
// Request/response handshakes and datapath control bundle for the modulo sequencer.
// slave = sequencer side, master = issuer/consumer/datapath side.
interface mod_seq_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 11
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rem;
    logic             rsp_err;
    logic [CNT_W-1:0] rsp_iters;

    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic             dp_s;
    logic             dp_we;
    logic             dp_x;
    logic [WIDTH-1:0] dp_result;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, dp_x, dp_result,
        output req_ready, rsp_valid, rsp_rem, rsp_err, rsp_iters, dp_a, dp_b, dp_s, dp_we
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, dp_x, dp_result,
        input  req_ready, rsp_valid, rsp_rem, rsp_err, rsp_iters, dp_a, dp_b, dp_s, dp_we
    );
endinterface

// File: rtl/mod_seq_ctrl.sv
// Sequencer for a repeated-subtraction modulo datapath. Accepts one (a,b) request,
// loads and iterates the datapath until it reports done, then returns remainder,
// error flag and iteration count. Divisor zero and iteration overrun report an error.
module mod_seq_ctrl #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_ITER = 1024,
    parameter int unsigned CNT_W    = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    mod_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StIter,
        StResp
    } state_e;

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_ITER);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dp_a_q, dp_a_d;
    logic [WIDTH-1:0] dp_b_q, dp_b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] iters_q, iters_d;

    // State, counter, held operands and registered response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dp_a_q  <= '0;
            dp_b_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            iters_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dp_a_q  <= dp_a_d;
            dp_b_q  <= dp_b_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            iters_q <= iters_d;
        end
    end

    // Next-state, response capture and datapath/handshake decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dp_a_d        = dp_a_q;
        dp_b_d        = dp_b_q;
        rem_d         = rem_q;
        err_d         = err_q;
        iters_d       = iters_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.dp_s      = 1'b1;
        bus.dp_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    dp_a_d = bus.req_a;
                    dp_b_d = bus.req_b;
                    cnt_d  = '0;
                    if (bus.req_b == '0) begin
                        // Divide by zero never touches the datapath.
                        state_d = StResp;
                        err_d   = 1'b1;
                        rem_d   = '0;
                        iters_d = '0;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                bus.dp_s = 1'b0;
                state_d  = StCheck;
            end
            StCheck: begin
                if (bus.dp_x) begin
                    state_d = StResp;
                    rem_d   = bus.dp_result;
                    err_d   = 1'b0;
                    iters_d = '0;
                end else begin
                    state_d = StIter;
                end
            end
            StIter: begin
                // Gated by dp_x so the datapath is not decremented on the done cycle.
                bus.dp_we = ~bus.dp_x;
                if (bus.dp_x) begin
                    state_d = StResp;
                    rem_d   = bus.dp_result;
                    err_d   = 1'b0;
                    iters_d = cnt_q;
                end else if (cnt_q == MaxCnt) begin
                    state_d = StResp;
                    rem_d   = '0;
                    err_d   = 1'b1;
                    iters_d = MaxCnt;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StResp: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.dp_a      = dp_a_q;
    assign bus.dp_b      = dp_b_q;
    assign bus.rsp_rem   = rem_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_iters = iters_q;

endmodule

// File: tb/tb_mod_seq_ctrl.sv
// Bench for mod_seq_ctrl: behavioural subtractive datapath on dp_*, a driver that
// pushes expected responses into a queue, and a monitor that checks them and the
// datapath control activity per operation.
module tb_mod_seq_ctrl;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned MAX_ITER = 8;
    localparam int unsigned CNT_W    = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rem;
        logic        err;
        int          iters;
        int          lat;
        int          we;
        int          ld;
        int          acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;
    bit   mon_en;
    int   stall_req;
    exp_t sb[$];

    mod_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    mod_seq_ctrl #(
        .WIDTH   (WIDTH),
        .MAX_ITER(MAX_ITER),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Behavioural datapath: load on dp_s=0, subtract b on dp_we.
    logic [31:0] w;
    initial w = '0;
    always_ff @(posedge clk) begin
        if (!bus.dp_s && !bus.dp_we) w <= bus.dp_a;
        else if (bus.dp_we) w <= w - bus.dp_b;
    end
    assign bus.dp_x      = (w < bus.dp_b);
    assign bus.dp_result = w;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected outcome of a request, from the arithmetic definition of modulo.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int acc);
        exp_t e;
        logic [31:0] q;
        e.a = a; e.b = b; e.acc = acc;
        if (b == 0) begin
            e.rem = 0; e.err = 1; e.iters = 0; e.lat = 1; e.we = 0; e.ld = 0;
        end else if (a < b) begin
            e.rem = a; e.err = 0; e.iters = 0; e.lat = 3; e.we = 0; e.ld = 1;
        end else begin
            q = a / b;
            e.ld = 1;
            if (q <= MAX_ITER) begin
                e.rem = a % b; e.err = 0; e.iters = int'(q);
                e.lat = 4 + int'(q); e.we = int'(q);
            end else begin
                e.rem = 0; e.err = 1; e.iters = MAX_ITER;
                e.lat = 4 + MAX_ITER; e.we = MAX_ITER + 1;
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int  waited;
        int  c;
        bit  acc;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        waited = 0;
        acc    = 0;
        c      = 0;
        while (!acc) begin
            @(negedge clk);
            if (bus.req_ready) begin
                acc = 1;
                c   = cyc;
            end else begin
                waited = waited + 1;
                if (waited > 500) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("FAIL accept_timeout: req_ready %0b after %0d cycles, required 1",
                             bus.req_ready, waited);
                    bus.req_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
        end
        #1;
        sb.push_back(model(a, b, c));
        bus.req_valid = 1'b0;
    endtask

    // Consumer: random backpressure, plus a forced long stall on request.
    initial begin
        int stall_left;
        int stall_seen;
        stall_left    = 0;
        stall_seen    = 0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_seen != stall_req) begin
                stall_seen = stall_req;
                stall_left = 10;
            end
            if (stall_left > 0) begin
                bus.rsp_ready = 1'b0;
                stall_left    = stall_left - 1;
            end else begin
                bus.rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: scoreboard pop on response handshake plus per-cycle control checks.
    initial begin
        bit prev_valid;
        int we_cnt;
        int ld_cnt;
        prev_valid = 0;
        we_cnt     = 0;
        ld_cnt     = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("req_ready_idle", {31'b0, bus.req_ready}, {31'b0, sb.size() == 0});
                if (bus.dp_we && bus.dp_x) chk("dp_we_on_done", 32'd1, 32'd0);
                if (sb.size() > 0) begin
                    chk("dp_a_held", bus.dp_a, sb[0].a);
                    chk("dp_b_held", bus.dp_b, sb[0].b);
                    we_cnt = we_cnt + int'(bus.dp_we);
                    ld_cnt = ld_cnt + int'(!bus.dp_s);
                end else begin
                    chk("idle_dp_ctrl", {30'b0, bus.dp_s, bus.dp_we}, 32'd2);
                end
                if (bus.rsp_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        if (!prev_valid) chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                        chk("rsp_rem", bus.rsp_rem, sb[0].rem);
                        chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, sb[0].err});
                        chk("rsp_iters", 32'(bus.rsp_iters), 32'(sb[0].iters));
                        if (bus.rsp_ready) begin
                            chk("dp_we_cycles", 32'(we_cnt), 32'(sb[0].we));
                            chk("dp_load_cycles", 32'(ld_cnt), 32'(sb[0].ld));
                            void'(sb.pop_front());
                            we_cnt = 0;
                            ld_cnt = 0;
                        end
                    end
                end
                prev_valid = bus.rsp_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        total         = 0;
        bad           = 0;
        mon_en        = 0;
        stall_req     = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        #2;
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rem", bus.rsp_rem, 32'd0);
        chk("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
        chk("rst_rsp_iters", 32'(bus.rsp_iters), 32'd0);
        chk("rst_dp_a", bus.dp_a, 32'd0);
        chk("rst_dp_s_we", {30'b0, bus.dp_s, bus.dp_we}, 32'd2);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Start a long operation and reset it asynchronously mid-iteration.
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_a     = 32'd1000;
        bus.req_b     = 32'd1;
        @(negedge clk);
        chk("pre_accept_ready", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        chk("iter_dp_we", {31'b0, bus.dp_we}, 32'd1);
        chk("iter_req_ready", {31'b0, bus.req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("async_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("async_rst_dp_s_we", {30'b0, bus.dp_s, bus.dp_we}, 32'd2);
        chk("async_rst_dp_a", bus.dp_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        mon_en = 1;

        // Directed cases.
        issue(32'd5, 32'd7);
        issue(32'd100, 32'd7);
        issue(32'd9, 32'd0);
        issue(32'd1000, 32'd1);
        issue(32'd8, 32'd1);
        issue(32'd9, 32'd1);
        issue(32'd7, 32'd7);
        issue(32'd0, 32'd3);
        stall_req = stall_req + 1;
        issue(32'd5, 32'd7);
        issue(32'd3, 32'd2);

        // Randomized requests.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom_range(0, 80);
            b = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) a = $urandom;
            if ($urandom_range(0, 15) == 0) b = $urandom;
            issue(a, b);
        end

        waited = 0;
        while (sb.size() > 0 && waited < 2000) begin
            @(posedge clk);
            waited = waited + 1;
        end
        if (sb.size() > 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
        end
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
